// File: rtl/jtcps1_vram_arb.sv
// Three-port read arbiter (scroll, object, palette) in front of a single shared VRAM read port.
// Fixed priority scr > obj > pal by default; define JTCPS1_VRAM_ARB_RR_EN for round-robin.
module jtcps1_vram_arb #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW:1]   scr_addr,
  input  logic          scr_cs,
  output logic [15:0]   scr_data,
  output logic          scr_ok,
  input  logic [AW:1]   obj_addr,
  input  logic          obj_cs,
  output logic [15:0]   obj_data,
  output logic          obj_ok,
  input  logic [AW:1]   pal_addr,
  input  logic          pal_cs,
  output logic [15:0]   pal_data,
  output logic          pal_ok,
  output logic [AW:1]   mem_addr,
  output logic          mem_req,
  input  logic [15:0]   mem_data,
  input  logic          mem_ack,
  output logic [1:0]    grant
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [AW:1] req_addr [3];
  logic [2:0]  req_cs;
  logic [2:0]  ok;
  logic [2:0]  pend;
  logic [2:0]  cap;

  logic [0:0]  state_q, state_d;
  logic [AW:1] mem_addr_q, mem_addr_d;
  logic [1:0]  grant_q, grant_d;
  logic        sel_vld;
  logic [1:0]  sel_idx;

  assign req_addr[0] = scr_addr;
  assign req_addr[1] = obj_addr;
  assign req_addr[2] = pal_addr;
  assign req_cs      = {pal_cs, obj_cs, scr_cs};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
      logic [15:0] data_q, data_d;
      logic [AW:1] lat_addr_q, lat_addr_d;
      logic        valid_q, valid_d;

      // ok only while the requester still asks for the very address that was fetched
      assign ok[gi]   = req_cs[gi] & valid_q & (req_addr[gi] == lat_addr_q);
      assign pend[gi] = req_cs[gi] & ~ok[gi];
      assign cap[gi]  = (state_q == ST_BUSY) & mem_ack & (grant_q == 2'(gi + 1));

      always_comb begin
        data_d     = cap[gi] ? mem_data   : data_q;
        lat_addr_d = cap[gi] ? mem_addr_q : lat_addr_q;
        valid_d    = req_cs[gi] & (valid_q | cap[gi]);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q     <= '0;
          lat_addr_q <= '0;
          valid_q    <= 1'b0;
        end else begin
          data_q     <= data_d;
          lat_addr_q <= lat_addr_d;
          valid_q    <= valid_d;
        end
      end
    end
  endgenerate

`ifdef JTCPS1_VRAM_ARB_RR_EN
  logic [1:0] last_q, last_d;
  logic [1:0] first_idx, second_idx, third_idx;

  // search starts at the port after the most recently granted one
  always_comb begin
    first_idx  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    second_idx = (first_idx == 2'd2) ? 2'd0 : first_idx + 2'd1;
    third_idx  = (second_idx == 2'd2) ? 2'd0 : second_idx + 2'd1;
    sel_vld    = 1'b1;
    sel_idx    = first_idx;
    if (pend[first_idx])       sel_idx = first_idx;
    else if (pend[second_idx]) sel_idx = second_idx;
    else if (pend[third_idx])  sel_idx = third_idx;
    else                       sel_vld = 1'b0;
    last_d = (state_q == ST_IDLE && sel_vld) ? sel_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 2'd0;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    sel_vld = 1'b1;
    sel_idx = 2'd0;
    if (pend[0])      sel_idx = 2'd0;
    else if (pend[1]) sel_idx = 2'd1;
    else if (pend[2]) sel_idx = 2'd2;
    else              sel_vld = 1'b0;
  end
`endif

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    grant_d    = grant_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = 2'd0;
        if (sel_vld) begin
          state_d    = ST_BUSY;
          mem_addr_d = req_addr[sel_idx];
          grant_d    = sel_idx + 2'd1;
        end
      end
      default: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          grant_d = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      grant_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      grant_q    <= grant_d;
    end
  end

  assign mem_req  = (state_q == ST_BUSY);
  assign mem_addr = mem_addr_q;
  assign grant    = grant_q;
  assign scr_ok   = ok[0];
  assign obj_ok   = ok[1];
  assign pal_ok   = ok[2];
  assign scr_data = g_port[0].data_q;
  assign obj_data = g_port[1].data_q;
  assign pal_data = g_port[2].data_q;
endmodule

// File: tb/tb_jtcps1_vram_arb.sv
// Scoreboard bench: a transaction-level model predicts grants and ok/data events,
// an independent monitor compares them against the arbiter outputs.
`timescale 1ns/1ps
module tb_jtcps1_vram_arb;
  localparam int AW = 17;
  localparam int N  = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    cs_v = '0;
  logic [AW:1]   addr_v [3];
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_data = '0;
  logic [15:0]   scr_data, obj_data, pal_data;
  logic          scr_ok, obj_ok, pal_ok, mem_req;
  logic [AW:1]   mem_addr;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  jtcps1_vram_arb #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .scr_addr(addr_v[0]), .scr_cs(cs_v[0]), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_addr(addr_v[1]), .obj_cs(cs_v[1]), .obj_data(obj_data), .obj_ok(obj_ok),
    .pal_addr(addr_v[2]), .pal_cs(cs_v[2]), .pal_data(pal_data), .pal_ok(pal_ok),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_data(mem_data), .mem_ack(mem_ack),
    .grant(grant)
  );

  typedef struct { int cyc; logic [1:0] g; logic [AW:1] a; } iss_t;
  typedef struct { int cyc; int port; logic [15:0] d; } ok_t;
  iss_t iss_q[$];
  ok_t  ok_q[$];
  int   rst_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // reference model state (transaction level)
  bit          m_busy;
  int          m_g;
  logic [AW:1] m_maddr;
  logic [15:0] m_data [3];
  logic [AW:1] m_lat [3];
  bit          m_valid [3];
  bit          m_ok [3];
  int          m_last;
  int          ack_wait;
  bit          did_rst;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d: event expected by model did not match DUT", name, cyc);
  endfunction

  function automatic int choose(bit [2:0] pend);
`ifdef JTCPS1_VRAM_ARB_RR_EN
    for (int k = 1; k <= 3; k++)
      if (pend[(m_last + k) % 3]) return (m_last + k) % 3;
`else
    for (int k = 0; k < 3; k++)
      if (pend[k]) return k;
`endif
    return -1;
  endfunction

  function automatic logic [AW:1] pick_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic drive_and_predict(input int n);
    bit [2:0] pend;
    bit       done, rnd, fin, load, ok_new;
    int       sel;
    iss_t     ie;
    ok_t      oe;
    rnd  = (n >= 400) && (n < N - 20);
    fin  = (n >= N - 20);
    load = (n >= 100) && (n < 400);
    // requesters
    for (int p = 0; p < 3; p++) begin
      if (fin) cs_v[p] = 1'b0;
      else if (cs_v[p] && m_ok[p]) begin
        if (load && p < 2) addr_v[p] = pick_addr();
        else cs_v[p] = 1'b0;
      end else if (!cs_v[p]) begin
        if ((rnd && $urandom_range(0, 3) == 0) || (load && p < 2)) begin
          cs_v[p] = 1'b1; addr_v[p] = pick_addr();
        end
      end else if (rnd) begin
        if ($urandom_range(0, 15) == 0) addr_v[p] = pick_addr();
        else if ($urandom_range(0, 31) == 0) cs_v[p] = 1'b0;
      end
    end
    if (n == 3) begin cs_v[0] = 1'b1; addr_v[0] = 17'h01234; end
    if (n == 22) begin
      cs_v = 3'b111; addr_v[0] = 17'h00100; addr_v[1] = 17'h00200; addr_v[2] = 17'h00300;
    end
    if (n == 62) begin cs_v[1] = 1'b1; addr_v[1] = 17'h00010; end
    if (n >= 60 && n < 100 && m_busy && m_g == 1 && addr_v[1] == 17'h00010) addr_v[1] = 17'h00020;
    if (n == 100) begin cs_v[2] = 1'b1; addr_v[2] = 17'h00055; end
    // memory responder
    rst = (n < 2);
    mem_ack = 1'b0;
    mem_data = 16'($urandom);
    if (!rst) begin
      if (m_busy) begin
        if (ack_wait == 0) begin
          mem_ack = 1'b1;
          if (n < 20) mem_data = 16'hBEEF;
          if (rnd && n >= 1500 && !did_rst) begin rst = 1'b1; did_rst = 1'b1; end
        end else ack_wait--;
      end else if (rnd && $urandom_range(0, 7) == 0) mem_ack = 1'b1;
    end
    // prediction for the coming edge
    if (rst) begin
      m_busy = 0; m_g = 0; m_maddr = '0; m_last = 0;
      for (int p = 0; p < 3; p++) begin m_data[p] = '0; m_lat[p] = '0; m_valid[p] = 0; end
      rst_q.push_back(n);
    end else begin
      for (int p = 0; p < 3; p++)
        pend[p] = cs_v[p] && !(m_valid[p] && m_lat[p] == addr_v[p]);
      done = m_busy && mem_ack;
      if (done) begin m_data[m_g] = mem_data; m_lat[m_g] = m_maddr; end
      for (int p = 0; p < 3; p++) begin
        if (!cs_v[p]) m_valid[p] = 0;
        else if (done && m_g == p) m_valid[p] = 1;
      end
      if (done) m_busy = 0;
      else if (!m_busy) begin
        sel = choose(pend);
        if (sel >= 0) begin
          m_busy = 1; m_g = sel; m_maddr = addr_v[sel]; m_last = sel;
          ie.cyc = n; ie.g = 2'(sel + 1); ie.a = addr_v[sel];
          iss_q.push_back(ie);
          ack_wait = (n < 20) ? 0 : (n < 60) ? 3 : (n < 100) ? 2 : int'($urandom_range(0, 3));
        end
      end
    end
    for (int p = 0; p < 3; p++) begin
      ok_new = cs_v[p] && m_valid[p] && (m_lat[p] == addr_v[p]);
      if (ok_new && !m_ok[p]) begin
        oe.cyc = n; oe.port = p; oe.d = m_data[p];
        ok_q.push_back(oe);
      end
      m_ok[p] = ok_new;
    end
  endtask

  initial begin
    for (int p = 0; p < 3; p++) begin
      addr_v[p] = '0; m_data[p] = '0; m_lat[p] = '0; m_valid[p] = 0; m_ok[p] = 0;
    end
    m_busy = 0; m_g = 0; m_maddr = '0; m_last = 0; ack_wait = 0; did_rst = 0;
    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      cyc = n;
      drive_and_predict(n);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("issue_queue_drained", 64'(iss_q.size()), 64'd0);
    chk("ok_queue_drained", 64'(ok_q.size()), 64'd0);
    chk("reset_queue_drained", 64'(rst_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // monitor
  initial begin
    logic        req_prev;
    logic [2:0]  okp, okn;
    logic [15:0] dv;
    iss_t        ie;
    ok_t         oe;
    req_prev = 1'b0;
    okp = '0;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      okn = {pal_ok, obj_ok, scr_ok};
      if (rst_q.size() > 0 && rst_q[0] == cyc) begin
        void'(rst_q.pop_front());
        chk("reset_ctl", 64'({mem_req, grant, okn}), 64'd0);
        chk("reset_data", 64'({scr_data, obj_data, pal_data}), 64'd0);
        chk("reset_addr", 64'(mem_addr), 64'd0);
      end
      if (mem_req === 1'b1 && req_prev !== 1'b1) begin
        if (iss_q.size() == 0) fail("unexpected_issue");
        else begin
          ie = iss_q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(ie.cyc));
          chk("grant", 64'(grant), 64'(ie.g));
          chk("mem_addr", 64'(mem_addr), 64'(ie.a));
          $display("txn cyc=%0d grant=%0d addr=%05h", cyc, grant, mem_addr);
        end
      end
      if (mem_req !== 1'b1) chk("idle_grant", 64'(grant), 64'd0);
      for (int p = 0; p < 3; p++) begin
        if (okn[p] === 1'b1 && okp[p] !== 1'b1) begin
          dv = (p == 0) ? scr_data : (p == 1) ? obj_data : pal_data;
          if (ok_q.size() == 0) fail("unexpected_ok");
          else begin
            oe = ok_q.pop_front();
            chk("ok_port", 64'(p), 64'(oe.port));
            chk("ok_cycle", 64'(cyc), 64'(oe.cyc));
            chk("ok_data", 64'(dv), 64'(oe.d));
          end
        end
      end
      while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
        void'(iss_q.pop_front());
        fail("missing_issue");
      end
      while (ok_q.size() > 0 && ok_q[0].cyc < cyc) begin
        void'(ok_q.pop_front());
        fail("missing_ok");
      end
      req_prev = mem_req;
      okp = okn;
    end
  end
endmodule

// File: doc/jtcps1_vram_arb.md
JTCPS1_VRAM_ARB -- requirements
Module: jtcps1_vram_arb

Interface
REQ-001 Parameter: AW, 17, address width; ports carry [AW:1] word addresses.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 scr_addr  input  AW  scroll requester word address.
REQ-005 scr_cs  input  1  scroll request; held high with scr_addr stable until scr_ok.
REQ-006 scr_data  output  16  scroll read data.
REQ-007 scr_ok  output  1  scroll data valid for current scr_addr.
REQ-008 obj_addr/obj_cs/obj_data/obj_ok: same widths, directions and meanings as REQ-004..007, object requester.
REQ-009 pal_addr/pal_cs/pal_data/pal_ok: same widths, directions and meanings as REQ-004..007, palette requester.
REQ-010 mem_addr  output  AW  shared VRAM read address.
REQ-011 mem_req  output  1  shared VRAM read request, level.
REQ-012 mem_data  input  16  shared VRAM read data, valid with mem_ack.
REQ-013 mem_ack  input  1  one-cycle completion pulse for the current mem_req.
REQ-014 grant  output  2  port being served: 0 none, 1 scr, 2 obj, 3 pal.

Function
REQ-015 Port i pending = i_cs & ~i_ok.
REQ-016 FSM has two states: IDLE and BUSY.
REQ-017 IDLE, any pending: select one port per REQ-024; on that edge latch its address into mem_addr, set grant, set mem_req=1, go BUSY.
REQ-018 IDLE, none pending: mem_req=0, grant=0, mem_addr holds last value.
REQ-019 BUSY: mem_addr, grant and mem_req=1 held stable until mem_ack.
REQ-020 BUSY, mem_ack: on that edge capture mem_data into the granted port's data register; store issued address as that port's lat_addr; set its valid; set mem_req=0 and grant=0; go IDLE.
REQ-021 i_ok = i_cs & valid_i & (i_addr == lat_addr_i); combinational from registers and current inputs.
REQ-022 valid_i cleared on any edge where i_cs=0; i_data holds its value until next capture.
REQ-023 Latency: cs high at edge 0 -> mem_req at edge 1; ack sampled at edge k -> ok high after edge k; minimum 2 cycles. At most one grant per IDLE cycle; back-to-back transactions separated by one IDLE cycle.
REQ-024 Fixed priority: scr > obj > pal.
REQ-025 Granted port drops cs in BUSY: transaction completes; data captured, ok stays low.
REQ-026 Granted port changes addr in BUSY: on completion ok stays low on address mismatch; port becomes pending again, new address served on a later grant.
REQ-027 mem_ack in IDLE is ignored; no register changes.
REQ-028 cs changes on non-granted ports never disturb a BUSY transaction.

Reset
REQ-029 On rst: state IDLE, mem_req=0, grant=0, mem_addr=0, all data registers 0, all valid 0, so all ok=0; RR pointer = scr.
REQ-030 rst mid-transaction: mem_req low after the reset edge; the in-flight result is discarded, including a mem_ack coincident with rst.

Configuration
REQ-031 Macro JTCPS1_VRAM_ARB_RR_EN.
REQ-032 Defined: round-robin; search order starts at the port after the last granted one (scr->obj->pal->scr); pointer updates on each grant.
REQ-033 Undefined: fixed priority per REQ-024; pal may starve under continuous scr/obj load.

Verification
REQ-034 scr_cs=1, scr_addr=0x01234; mem_ack one cycle after mem_req with mem_data=0xBEEF -> mem_addr=0x01234, grant=1, then scr_data=0xBEEF, scr_ok=1, 2 cycles after cs.
REQ-035 scr, obj, pal all request at the same edge, ack latency 3 -> fixed build grant order 1,2,3; RR_EN build after prior scr grant gives 2,3,1; each ok only on its own port.
REQ-036 obj granted; obj_addr changes 0x00010->0x00020 before ack -> obj_ok stays low; second mem_req at 0x00020; obj_ok=1 with the new data.
REQ-037 rst pulsed while BUSY, mem_ack coincident -> mem_req=0, grant=0, all ok=0, all data=0 after the edge.
REQ-038 pal_cs held 1 while scr and obj request continuously -> fixed build: no pal grant; RR_EN build: pal granted within 3 transactions.
